// File: rtl/miller_pkg.sv
// ============================================================================
// Module      : miller_pkg
// Description : Shared types and threshold helpers for the Miller decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package miller_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } miller_state_e;

    typedef enum logic {
        MID = 1'b0,
        BND = 1'b1
    } miller_phase_e;

    typedef enum logic [2:0] {
        GLITCH  = 3'd0,
        I2      = 3'd1,
        I3      = 3'd2,
        I4      = 3'd3,
        TIMEOUT = 3'd4
    } miller_class_e;

    // Interval thresholds sit at odd multiples of half a half-bit: n*H/2.
    function automatic int unsigned half_mult(input int unsigned h, input int unsigned n);
        return (n * h) / 2;
    endfunction

    // Counter saturates at 5*H, so it needs enough bits to hold that value.
    function automatic int unsigned cnt_width(input int unsigned h);
        return $clog2(5 * h + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/miller_edge_detect.sv
// ============================================================================
// Module      : miller_edge_detect
// Description : 2-flop synchroniser, optional majority-of-3 filter
//               (DECODER_MILLER_GLITCH_FILTER_EN) and registered edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module miller_edge_detect (
    input  logic clk_100m,
    input  logic rst_n,
    input  logic i_line,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic r_edge;
    logic w_level;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DECODER_MILLER_GLITCH_FILTER_EN
    logic r_hist1;
    logic r_hist2;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    // Combinational vote keeps the added latency to exactly one cycle.
    assign w_level = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_edge    <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_edge    <= w_level ^ r_level_d;
        end
    end

    assign o_edge = r_edge;

endmodule

`default_nettype wire

// File: rtl/decoder_miller.sv
// ============================================================================
// Module      : decoder_miller
// Description : Miller line decoder - interval counter, edge classifier and
//               HUNT/DATA FSM. Optional DECODER_MILLER_GLITCH_FILTER_EN adds
//               an input majority filter (one extra cycle of latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_miller
    import miller_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = 8
) (
    input  logic clk_100m,
    input  logic rst_n,
    input  logic miller_code_i,
    output logic code_o,
    output logic code_valid_o,
    output logic locked_o,
    output logic err_o
);

    localparam int unsigned c_cnt_w = cnt_width(HALF_BIT_CYCLES);

    localparam logic [c_cnt_w-1:0] c_thr_i2  = c_cnt_w'(half_mult(HALF_BIT_CYCLES, 3));
    localparam logic [c_cnt_w-1:0] c_thr_i3  = c_cnt_w'(half_mult(HALF_BIT_CYCLES, 5));
    localparam logic [c_cnt_w-1:0] c_thr_i4  = c_cnt_w'(half_mult(HALF_BIT_CYCLES, 7));
    localparam logic [c_cnt_w-1:0] c_thr_to  = c_cnt_w'(half_mult(HALF_BIT_CYCLES, 9));
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(5 * HALF_BIT_CYCLES);

    logic               w_edge;
    logic [c_cnt_w-1:0] r_cnt;
    miller_class_e      w_class;
    logic               w_timeout;

    miller_state_e      r_state;
    miller_state_e      w_state_nxt;
    miller_phase_e      r_phase;
    miller_phase_e      w_phase_nxt;
    logic               r_pend;
    logic               w_pend_nxt;
    logic               r_code;
    logic               w_code_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_viol;

    miller_edge_detect u_edge_detect (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .i_line   (miller_code_i),
        .o_edge   (w_edge)
    );

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_class = TIMEOUT;
        if (r_cnt < c_thr_i2) begin
            w_class = GLITCH;
        end else if (r_cnt < c_thr_i3) begin
            w_class = I2;
        end else if (r_cnt < c_thr_i4) begin
            w_class = I3;
        end else if (r_cnt < c_thr_to) begin
            w_class = I4;
        end
    end

    // Equality (not >=) so a stuck line raises exactly one timeout.
    assign w_timeout = !w_edge && (r_cnt == c_thr_to);

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_phase <= BND;
            r_pend  <= 1'b0;
            r_code  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_pend  <= w_pend_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_pend_nxt  = 1'b0;
        w_valid_nxt = r_pend;
        w_code_nxt  = r_pend;
        w_err_nxt   = 1'b0;
        w_viol      = 1'b0;

        if (r_state == HUNT) begin
            if (w_edge) begin
                w_state_nxt = DATA;
                w_phase_nxt = BND;
            end
        end else begin
            if (w_edge) begin
                case (w_class)
                    I2: begin
                        w_valid_nxt = 1'b1;
                        w_code_nxt  = (r_phase == MID);
                    end
                    I3: begin
                        w_valid_nxt = 1'b1;
                        w_code_nxt  = 1'b0;
                        if (r_phase == MID) begin
                            w_phase_nxt = BND;
                        end else begin
                            w_pend_nxt  = 1'b1;
                            w_phase_nxt = MID;
                        end
                    end
                    I4: begin
                        if (r_phase == MID) begin
                            w_valid_nxt = 1'b1;
                            w_code_nxt  = 1'b0;
                            w_pend_nxt  = 1'b1;
                        end else begin
                            w_viol = 1'b1;
                        end
                    end
                    default: w_viol = 1'b1;
                endcase
            end else if (w_timeout) begin
                w_viol = 1'b1;
            end
        end

        // A violation also swallows any queued second bit.
        if (w_viol) begin
            w_state_nxt = HUNT;
            w_phase_nxt = BND;
            w_pend_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
            w_code_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
        end
    end

    assign code_o       = r_code;
    assign code_valid_o = r_valid;
    assign err_o        = r_err;
    assign locked_o     = (r_state == DATA);

endmodule

`default_nettype wire

// File: tb/tb_decoder_miller.sv
// ============================================================================
// Module      : tb_decoder_miller
// Description : Directed self-checking bench for decoder_miller (H=8); honours
//               DECODER_MILLER_GLITCH_FILTER_EN for the filtered build.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_decoder_miller;

    localparam int unsigned H = 8;
`ifdef DECODER_MILLER_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk_100m      = 1'b0;
    logic rst_n         = 1'b0;
    logic miller_code_i = 1'b0;
    logic code_o;
    logic code_valid_o;
    logic locked_o;
    logic err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Preamble 0,0,0,0 then data 1,0,1,1 (bit k = stream_bits[k]).
    logic [7:0] stream_bits = 8'b1101_0000;
    // Line-change iteration behind each strobe (+1 for a queued second bit).
    int   strobe_t [7] = '{32, 48, 72, 73, 104, 105, 120};
    logic strobe_v [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    decoder_miller #(.HALF_BIT_CYCLES(H)) dut (
        .clk_100m      (clk_100m),
        .rst_n         (rst_n),
        .miller_code_i (miller_code_i),
        .code_o        (code_o),
        .code_valid_o  (code_valid_o),
        .locked_o      (locked_o),
        .err_o         (err_o)
    );

    always #5 clk_100m = ~clk_100m;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        miller_code_i = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // {valid, code qualified by valid, err, locked}
    function automatic logic [3:0] observe();
        return {code_valid_o, code_valid_o & code_o, err_o, locked_o};
    endfunction

    // Miller encoder: a 1 toggles mid-bit, a 0 after a 0 toggles at the boundary.
    function automatic logic enc_level(input int t);
        logic lvl;
        logic prev;
        lvl  = 1'b0;
        prev = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!stream_bits[k] && !prev && t >= 2 * int'(H) * k) lvl = ~lvl;
            if (stream_bits[k] && t >= 2 * int'(H) * k + int'(H)) lvl = ~lvl;
            prev = stream_bits[k];
        end
        return lvl;
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        rst_n         = 1'b0;
        miller_code_i = 1'b0;
        repeat (3) tick();
        obs = observe();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got v/c/e/l=%b expected %b", obs, 4'b0000);
        end
        rst_n = 1'b1;
        tick();
        obs = observe();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: got v/c/e/l=%b expected %b", obs, 4'b0000);
        end
    endtask

    task automatic test_stream();
        logic [3:0] exp;
        logic [3:0] obs;
        do_reset();
        for (int i = 0; i <= 150; i++) begin
            miller_code_i = enc_level(i);
`ifdef DECODER_MILLER_GLITCH_FILTER_EN
            if (i == 60 || i == 90) miller_code_i = ~miller_code_i;
`endif
            tick();
            exp = {3'b000, (i >= 16 + LAT)};
            for (int s = 0; s < 7; s++) begin
                if (i == strobe_t[s] + LAT) exp[3:2] = {1'b1, strobe_v[s]};
            end
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stream @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp;
        logic [3:0] obs;
        do_reset();
        for (int i = 0; i <= 60; i++) begin
            if (i == 2) miller_code_i = ~miller_code_i;
            tick();
            exp = {2'b00, (i == 2 + 37 + LAT), (i >= 2 + LAT && i < 2 + 37 + LAT)};
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL timeout @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        logic [3:0] obs;
        do_reset();
        for (int i = 0; i <= 45; i++) begin
            if (i == 2 || i == 18 || i == 26 || i == 31) miller_code_i = ~miller_code_i;
            tick();
            exp = {(i == 18 + LAT), 1'b0, (i == 26 + LAT),
                   ((i >= 2 + LAT && i < 26 + LAT) || i >= 31 + LAT)};
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL glitch @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_i4_bnd();
        logic [3:0] exp;
        logic [3:0] obs;
        do_reset();
        for (int i = 0; i <= 50; i++) begin
            if (i == 2 || i == 35) miller_code_i = ~miller_code_i;
            tick();
            exp = {2'b00, (i == 35 + LAT), (i >= 2 + LAT && i < 35 + LAT)};
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL i4_bnd @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_mid_i3();
        logic [3:0] exp;
        logic [3:0] obs;
        do_reset();
        for (int i = 0; i <= 80; i++) begin
            if (i == 2 || i == 26 || i == 50 || i == 66) miller_code_i = ~miller_code_i;
            tick();
            exp = {1'b0, 1'b0, 1'b0, (i >= 2 + LAT)};
            if (i == 26 + LAT || i == 50 + LAT || i == 66 + LAT) exp[3:2] = 2'b10;
            if (i == 27 + LAT) exp[3:2] = 2'b11;
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mid_i3 @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp;
        logic [3:0] obs;
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            if (i == 2 || i == 26 || i == 27) miller_code_i = ~miller_code_i;
            tick();
            exp = {(i == 26 + LAT), 1'b0, (i == 27 + LAT), (i >= 2 + LAT && i < 27 + LAT)};
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL priority @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        logic [3:0] obs;
        do_reset();
        for (int i = 0; i <= 26 + LAT; i++) begin
            if (i == 2 || i == 26) miller_code_i = ~miller_code_i;
            tick();
            exp = {(i == 26 + LAT), 1'b0, 1'b0, (i >= 2 + LAT)};
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
        rst_n = 1'b0;
        #1;
        obs = observe();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got v/c/e/l=%b expected %b", obs, 4'b0000);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = observe();
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_mid_post @%0d: got v/c/e/l=%b expected %b", i, obs, 4'b0000);
            end
        end
        for (int i = 0; i < 15; i++) begin
            if (i == 0) miller_code_i = ~miller_code_i;
            tick();
            exp = {3'b000, (i >= LAT)};
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_relock @%0d: got v/c/e/l=%b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_timeout();
        test_glitch();
        test_i4_bnd();
        test_mid_i3();
`ifndef DECODER_MILLER_GLITCH_FILTER_EN
        test_priority();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
